// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one combinational shifter between the ALU (req0)
// and the mul/div sequencer (req1); result returned registered with owner ID.
module shift_arbiter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] in0,
  input  logic [CNT_W-1:0] cnt0,
  input  logic [1:0]       op0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] in1,
  input  logic [CNT_W-1:0] cnt1,
  input  logic [1:0]       op1,
  output logic             gnt1,
  input  logic             stall,
  output logic [WIDTH-1:0] sh_in,
  output logic [CNT_W-1:0] sh_cnt,
  output logic [1:0]       sh_op,
  input  logic [WIDTH-1:0] sh_out,
  output logic [WIDTH-1:0] res,
  output logic             res_valid,
  output logic             res_id,
  output logic [7:0]       busy_cnt
);

  logic             prio;
  logic             denied;
  logic [WIDTH-1:0] res_p1;
  logic             vld_p1;
  logic             id_p1;
  logic [7:0]       busyCnt;

  function automatic logic [7:0] satInc(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

  // Stage p0: combinational grant and shifter operand mux
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && !stall) begin
      if (req0 && req1) begin
        gnt0 = ~prio;
        gnt1 = prio;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign sh_in  = gnt1 ? in1  : in0;
  assign sh_cnt = gnt1 ? cnt1 : cnt0;
  assign sh_op  = gnt1 ? op1  : op0;
  assign denied = (req0 && !gnt0) || (req1 && !gnt1);

  // Stage p1: captured result, owner and bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      res_p1  <= '0;
      vld_p1  <= 1'b0;
      id_p1   <= 1'b0;
      prio    <= 1'b0;
      busyCnt <= 8'd0;
    end else begin
      vld_p1 <= gnt0 | gnt1;
      if (gnt0 || gnt1) begin
        res_p1 <= sh_out;
        id_p1  <= gnt1;
        // Next contention favours whoever was not just served.
        prio   <= ~gnt1;
      end
      if (denied) busyCnt <= satInc(busyCnt);
    end
  end

  assign res       = res_p1;
  assign res_valid = vld_p1;
  assign res_id    = id_p1;
  assign busy_cnt  = busyCnt;

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one combinational 16-bit shift unit between two requesters: req0 is the execute-stage ALU and req1 is the multi-cycle multiply/divide sequencer.
- Arbitrates each cycle with round-robin priority and drives the shared shifter's operand, count and op inputs.
- Registers the shifter result and returns it with a valid pulse and a requester ID.
- Supports a pipeline stall that freezes arbitration.

Parameters:
- WIDTH, 16, data width of operands and result.
- CNT_W, 4, shift-count width; must satisfy 2^CNT_W = WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- req0  input  1  requester 0 wants a shift this cycle.
- in0  input  WIDTH  requester 0 operand.
- cnt0  input  CNT_W  requester 0 shift amount.
- op0  input  2  requester 0 op: 00 shift left logical, 01 rotate left, 10 shift right logical, 11 shift right arithmetic.
- gnt0  output  1  requester 0 accepted this cycle (combinational).
- req1, in1, cnt1, op1  input  1/WIDTH/CNT_W/2  requester 1 equivalents.
- gnt1  output  1  requester 1 accepted this cycle (combinational).
- stall  input  1  pipeline stall; blocks new grants.
- sh_in  output  WIDTH  operand to the shared shifter.
- sh_cnt  output  CNT_W  count to the shared shifter.
- sh_op  output  2  op to the shared shifter.
- sh_out  input  WIDTH  shared shifter result (combinational from sh_in/sh_cnt/sh_op).
- res  output  WIDTH  registered result.
- res_valid  output  1  res holds a new result this cycle (one-cycle pulse).
- res_id  output  1  requester that owns res.
- busy_cnt  output  8  saturating count of cycles in which a request was denied.

Behaviour:
- Reset (rst high at clk edge): res=0, res_valid=0, res_id=0, busy_cnt=0, priority pointer prio=0. gnt0/gnt1 are forced 0 while rst is high. rst has precedence over every other input.
- Grant, combinational, at most one per cycle:
  - If stall=1 or rst=1: gnt0=gnt1=0.
  - Only req0: gnt0=1. Only req1: gnt1=1.
  - Both requesting: grant goes to the requester indexed by prio.
- Mux: sh_in/sh_cnt/sh_op come from requester 1 when gnt1=1; otherwise from requester 0, including the idle case, so the shifter inputs never float.
- Handshake:
  - The grant cycle is the acceptance cycle.
  - A requester holds req and its operands stable until it sees its gnt.
  - It may deassert req in any cycle without a grant; no pending state is kept for it.
- Capture, at clk edge in a grant cycle: res<=sh_out, res_id<=granted index, res_valid<=1. Latency is 1 cycle: the result is visible the cycle after the grant.
- No grant this cycle: res_valid<=0 next cycle; res and res_id hold their values.
- Priority pointer: updates only on a grant. After a grant to k, prio<=~k. It holds during stall and idle cycles.
- busy_cnt: increments by 1 per cycle in which at least one req is high and that requester is not granted, including stalled cycles. It saturates at 255 and never wraps.
- Back-to-back: a new grant may occur every cycle. res_valid stays high across consecutive grants, and res_id may alternate.
- Stall asserted in the cycle after a grant: the already-captured result still presents res_valid=1. Stall affects only new acceptances.
- Reset mid-operation: a grant in the same cycle as rst is discarded; no res_valid follows.
- Shift semantics are owned by the shifter. The arbiter passes count and op through unmodified; count 0 returns the operand unchanged.

Test Plan:
- Reset: hold rst 2 cycles with req0=req1=1 -> gnt0=gnt1=0, res=0, res_valid=0, busy_cnt=0; first cycle after rst, gnt0=1 (prio=0).
- Single requester: req0=1, in0=16'h0001, cnt0=4'd4, op0=00 -> gnt0=1 same cycle; next cycle res=16'h0010, res_valid=1, res_id=0.
- Contention alternation: req0=req1=1 for 4 cycles, in0=16'h00F0, in1=16'h8001, cnt=1, op0=00, op1=01 -> grants 0,1,0,1; results 16'h01E0, 16'h0003, 16'h01E0, 16'h0003; busy_cnt=4.
- Stall: req1=1 with stall=1 for 3 cycles, then stall=0 -> no grant for 3 cycles, busy_cnt=3, prio unchanged; gnt1 on the 4th cycle, res_valid the cycle after.
- Saturation: req0=req1=1 for 600 cycles -> busy_cnt=255 and holds; grant counts per requester differ by at most 1.
- Reset collision: grant cycle coincides with rst=1 -> no res_valid next cycle, prio=0, res=0.
